// File: rtl/add_tc_pipe.sv
// add_tc_pipe: pipelined two's-complement adder/subtractor.
// One SEG_W-bit carry-lookahead segment is resolved per stage; the segment
// carry, the not-yet-consumed operand bits and the finished low sum bits are
// registered between stages. The result is WIDTH+1 bits and always exact.
// Optional macro ADD_TC_PIPE_OVF_EN adds a registered 'ovf' output that flags
// a result not representable in WIDTH bits.
// WIDTH must be a non-zero multiple of SEG_W.
module add_tc_pipe #(
   parameter int WIDTH = 16,
   parameter int SEG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
`ifdef ADD_TC_PIPE_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NUM_SEG = WIDTH / SEG_W;

   // Single global enable: the whole pipe moves together or holds together,
   // so bubbles are never collapsed and a stalled output stays stable.
   logic adv;
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Segment adder: every internal carry is formed directly from the
   // generate/propagate terms of the lower bits and the segment carry-in.
   function automatic logic [SEG_W:0] cla_seg(input logic [SEG_W-1:0] x,
                                              input logic [SEG_W-1:0] y,
                                              input logic             ci);
      logic [SEG_W-1:0] g, p, s;
      logic [SEG_W:0]   c;
      logic             t, pp;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < SEG_W; i++) begin
         t  = g[i];
         pp = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            t  = t | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = t | (pp & ci);
      end
      s = p ^ c[SEG_W-1:0];
      return {c[SEG_W], s};
   endfunction

   for (genvar k = 0; k < NUM_SEG; k++) begin : g_stg
      localparam int LO  = k * SEG_W;   // lowest bit resolved in this stage
      localparam int REM = WIDTH - LO;  // operand bits still to be consumed

      logic [REM-1:0]        a_in, b_in;
      logic                  c_in, v_in;
      logic [SEG_W:0]        seg;
      logic [LO+SEG_W-1:0]   s_d, s_q;
      logic                  v_q;

      if (k == 0) begin : g_head
         // Gate operands with in_valid so X on idle inputs never enters the pipe.
         assign a_in = in_valid ? a : '0;
         assign b_in = in_valid ? (sub ? ~b : b) : '0;
         assign c_in = in_valid & sub;
         assign v_in = in_valid;
         assign s_d  = seg[SEG_W-1:0];
      end else begin : g_body
         assign a_in = g_stg[k-1].g_fwd.a_q;
         assign b_in = g_stg[k-1].g_fwd.b_q;
         assign c_in = g_stg[k-1].g_fwd.c_q;
         assign v_in = g_stg[k-1].v_q;
         assign s_d  = {seg[SEG_W-1:0], g_stg[k-1].s_q};
      end

      assign seg = cla_seg(a_in[SEG_W-1:0], b_in[SEG_W-1:0], c_in);

      // Stage valid bit and the sum bits finished so far.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_in;
            s_q <= s_d;
         end
      end

      if (k < NUM_SEG - 1) begin : g_fwd
         logic [REM-SEG_W-1:0] a_q, b_q;
         logic                 c_q;

         // Forward the unconsumed operand bits and the segment carry.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
               c_q <= 1'b0;
            end else if (adv) begin
               a_q <= a_in[REM-1:SEG_W];
               b_q <= b_in[REM-1:SEG_W];
               c_q <= seg[SEG_W];
            end
         end
      end else begin : g_tail
         logic msb_d, msb_q;

         // True sign extension of the top bit, not OR of carry and sign.
         assign msb_d = a_in[REM-1] ^ b_in[REM-1] ^ seg[SEG_W];

         // Result sign bit, aligned with the rest of the sum.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   msb_q <= 1'b0;
            else if (adv) msb_q <= msb_d;
         end

`ifdef ADD_TC_PIPE_OVF_EN
         logic ovf_q;

         // Result does not fit in WIDTH bits when the two top bits differ.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   ovf_q <= 1'b0;
            else if (adv) ovf_q <= msb_d ^ s_d[WIDTH-1];
         end
`endif
      end
   end

   assign out_valid = g_stg[NUM_SEG-1].v_q;
   assign sum       = {g_stg[NUM_SEG-1].g_tail.msb_q, g_stg[NUM_SEG-1].s_q};
`ifdef ADD_TC_PIPE_OVF_EN
   assign ovf       = g_stg[NUM_SEG-1].g_tail.ovf_q;
`endif

endmodule

// File: tb/tb_add_tc_pipe.sv
// Testbench for add_tc_pipe (WIDTH=16, SEG_W=4, latency 4).
// Directed table, back-to-back random traffic, stall and mid-flight reset,
// all checked through an in-order scoreboard.
module tb_add_tc_pipe;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         sub = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid;
   logic [W:0]   sum;
`ifdef ADD_TC_PIPE_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W:0]   exp;
   } vec_t;

   vec_t       vecs[8];
   logic [W:0] sb_q[$];
   logic [W:0] m_exp;

   add_tc_pipe #(.WIDTH(W), .SEG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
`ifdef ADD_TC_PIPE_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Reference: sign-extend both operands to W+1 bits and add or subtract.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic s);
      logic [W:0] xe, ye;
      xe = {x[W-1], x};
      ye = {y[W-1], y};
      return s ? (xe - ye) : (xe + ye);
   endfunction

   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Present one operand set, wait for acceptance, record its expected result.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input logic [W:0] e);
      int n;
      n        = 0;
      a        = x;
      b        = y;
      sub      = s;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout in_ready=%b expected 1", in_ready);
      end else begin
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, (W+1)'(sb_q.size()), '0);
   endtask

   // Scoreboard consumer: every handshaked output must match the oldest entry.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else if (out_valid && out_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_output sum=%h expected no output", sum);
         end else begin
            m_exp = sb_q.pop_front();
            if (sum !== m_exp) begin
               errors++;
               $display("FAIL result sum=%h expected=%h", sum, m_exp);
            end
`ifdef ADD_TC_PIPE_OVF_EN
            checks++;
            if (ovf !== (m_exp[W] ^ m_exp[W-1])) begin
               errors++;
               $display("FAIL ovf actual=%b expected=%b sum=%h", ovf, m_exp[W] ^ m_exp[W-1], m_exp);
            end
`endif
         end
      end
   end

   initial begin
      int         n;
      logic [W:0] held;
      logic [W-1:0] x, y;
      logic       s;

      vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000};
      vecs[1] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
      vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 17'h00000};
      vecs[3] = '{16'h0000, 16'h8000, 1'b1, 17'h08000};
      vecs[4] = '{16'h0005, 16'h0007, 1'b1, 17'h1FFFE};
      vecs[5] = '{16'h7FFF, 16'h8000, 1'b1, 17'h0FFFF};
      vecs[6] = '{16'h8000, 16'h7FFF, 1'b1, 17'h10001};
      vecs[7] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", (W+1)'(out_valid), '0);
      chk("rst_sum", sum, '0);
      chk("rst_in_ready", (W+1)'(in_ready), 17'd1);
`ifdef ADD_TC_PIPE_OVF_EN
      chk("rst_ovf", (W+1)'(ovf), '0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency of a single isolated transaction
      send(vecs[0].a, vecs[0].b, vecs[0].sub, vecs[0].exp);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", (W+1)'(n), 17'd4);
      drain("latency_drain");

      // Directed table, back to back
      for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("table_drain", (W+1)'(sb_q.size()), '0);

      // Random, back to back; must drain exactly latency cycles after the last
      for (int i = 0; i < 20; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         s = 1'($urandom_range(0, 1));
         send(x, y, s, model(x, y, s));
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("b2b_throughput", (W+1)'(sb_q.size()), '0);

      // Stall: fill the pipe with out_ready low, then hold for 5 cycles
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         s = 1'(i & 1);
         send(x, y, s, model(x, y, s));
      end
      in_valid = 1'b0;
      @(negedge clk);
      held = sum;
      chk("stall_head", held, sb_q[0]);
      for (int i = 0; i < 5; i++) begin
         chk("stall_out_valid", (W+1)'(out_valid), 17'd1);
         chk("stall_in_ready", (W+1)'(in_ready), '0);
         chk("stall_sum_stable", sum, held);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain("stall_drain");

      // Reset with three transactions in flight behind a valid output
      for (int i = 0; i < 4; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         send(x, y, 1'b0, model(x, y, 1'b0));
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", (W+1)'(out_valid), '0);
      chk("rst_mid_sum", sum, '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_rst_no_output", (W+1)'(out_valid), '0);
         chk("post_rst_in_ready", (W+1)'(in_ready), 17'd1);
      end

      // Traffic resumes cleanly after reset
      send(16'h0000, 16'h0001, 1'b1, 17'h1FFFF);
      in_valid = 1'b0;
      drain("post_rst_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
